imm_ext_pipe: RTL and testbench

- Parametrised, pipelined successor to the combinational sign extender.
- Takes an IN_W-bit immediate and produces an OUT_W-bit operand in one of four modes: zero, sign, high-placement, or sign-extend-then-shift.
- Sits between the instruction decoder and the ALU operand mux.
- One registered stage plus a skid buffer with valid/ready on both sides, so decode stalls never drop or duplicate an immediate.

---
 rtl/imm_ext_pipe_pkg.sv | 73 +++++++
 rtl/imm_ext_pipe_skid_buf.sv | 61 ++++++
 rtl/imm_ext_pipe.sv | 59 +++++
 tb/tb_imm_ext_pipe.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_ext_pipe_pkg.sv
// Shared definitions for the immediate-extension pipe.
// Latency: none. This is a package of types, constants and a pure function.
// Backpressure: not applicable.
//
// Contents: ext_mode_e (extension mode encodings), MAX_W (widest operand the
// helper supports), and ext_calc (extended value plus shift-overflow flag).
package imm_ext_pipe_pkg;

    // The helper works on MAX_W-bit containers, so one function covers every
    // IN_W/OUT_W pairing up to this width.
    localparam int MAX_W = 64;

    typedef enum logic [1:0] {
        EXT_ZERO  = 2'b00,
        EXT_SIGN  = 2'b01,
        EXT_HIGH  = 2'b10,
        EXT_SHIFT = 2'b11
    } ext_mode_e;

    // Returns the out_w-bit extended operand, zero-padded to MAX_W bits.
    // ovf is set only in EXT_SHIFT mode, when an arithmetic shift back by the
    // same amount does not recover the sign-extended input.
    function automatic logic [MAX_W-1:0] ext_calc(
        input  logic [MAX_W-1:0] imm,
        input  ext_mode_e        mode,
        input  int unsigned      shamt,
        input  int unsigned      in_w,
        input  int unsigned      out_w,
        output logic             ovf
    );
        logic [MAX_W-1:0]        in_mask;
        logic [MAX_W-1:0]        out_mask;
        logic [MAX_W-1:0]        zext;
        logic [MAX_W-1:0]        sext;
        logic [MAX_W-1:0]        shl;
        logic [MAX_W-1:0]        shl_se;
        logic signed [MAX_W-1:0] back_s;
        logic [MAX_W-1:0]        back;
        logic [MAX_W-1:0]        res;
        logic                    in_sign;
        logic                    out_sign;

        in_mask  = (in_w  >= MAX_W) ? '1 : ((64'd1 << in_w)  - 64'd1);
        out_mask = (out_w >= MAX_W) ? '1 : ((64'd1 << out_w) - 64'd1);

        zext    = imm & in_mask;
        in_sign = |(zext & (64'd1 << (in_w - 1)));
        sext    = (zext | (in_sign ? ~in_mask : '0)) & out_mask;

        // Shift inside the out_w window, then re-extend the truncated result
        // so the arithmetic right shift sees the out_w-bit sign.
        shl      = (sext << shamt) & out_mask;
        out_sign = |(shl & (64'd1 << (out_w - 1)));
        shl_se   = shl | (out_sign ? ~out_mask : '0);
        // Kept in its own statement so the shift stays arithmetic.
        back_s   = $signed(shl_se) >>> shamt;
        back     = back_s & out_mask;

        res = zext;
        ovf = 1'b0;
        case (mode)
            EXT_ZERO:  res = zext;
            EXT_SIGN:  res = sext;
            EXT_HIGH:  res = (zext << (out_w - in_w)) & out_mask;
            EXT_SHIFT: begin
                res = shl;
                ovf = (back != sext);
            end
        endcase
        return res;
    endfunction

endpackage

// File: rtl/imm_ext_pipe_skid_buf.sv
// Purpose: one-stage valid/ready register with a single skid slot, W bits wide.
// Latency: 1 cycle accept-to-output when unstalled; full 1 word/cycle throughput.
// Backpressure: a word arriving while the output is stalled parks in the skid
//               slot; in_rdy is the registered inverse of skid occupancy, so it
//               has no combinational path from out_rdy.
//
// Ports: core_clk, arst_n (async active-low), in_vld/in_rdy/in_dat (upstream),
//        out_vld/out_rdy/out_dat (downstream).
module imm_ext_pipe_skid_buf #(
    parameter int W = 17
) (
    input  logic         core_clk,
    input  logic         arst_n,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [W-1:0] in_dat,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_dat
);

    logic         out_vld_q;
    logic [W-1:0] out_dat_q;
    logic         skid_vld_q;
    logic [W-1:0] skid_dat_q;
    logic         accept;
    logic         load;

    assign in_rdy  = ~skid_vld_q;
    assign accept  = in_vld & in_rdy;
    // Output register may take a new word when empty or being drained.
    assign load    = ~out_vld_q | out_rdy;
    assign out_vld = out_vld_q;
    assign out_dat = out_dat_q;

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            out_vld_q  <= 1'b0;
            out_dat_q  <= '0;
            skid_vld_q <= 1'b0;
            skid_dat_q <= '0;
        end else if (load) begin
            // With the skid slot full in_rdy is low, so nothing new arrives
            // this cycle and the parked word moves up in order.
            if (skid_vld_q) begin
                out_vld_q  <= 1'b1;
                out_dat_q  <= skid_dat_q;
                skid_vld_q <= 1'b0;
            end else begin
                out_vld_q <= accept;
                if (accept) begin
                    out_dat_q <= in_dat;
                end
            end
        end else if (accept) begin
            skid_vld_q <= 1'b1;
            skid_dat_q <= in_dat;
        end
    end

endmodule

// File: rtl/imm_ext_pipe.sv
// Purpose: registered immediate extender (zero / sign / high / sign-shift) feeding the ALU operand mux.
// Latency: 1 cycle accept-to-o_valid when unstalled; 1 word/cycle throughput.
// Backpressure: one skid slot absorbs the word in flight on a stall; o_ready is registered.
//
// Ports: i_clk, i_rst_n (async active-low); i_valid/o_ready/i_signal/i_mode/i_shamt
//        upstream; o_valid/i_ready/o_signal/o_ovf downstream. o_ovf is only
//        meaningful in shift mode (i_mode 2'b11).
module imm_ext_pipe
    import imm_ext_pipe_pkg::*;
#(
    parameter int IN_W    = 11,
    parameter int OUT_W   = 16,
    parameter int SHAMT_W = 3
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [IN_W-1:0]    i_signal,
    input  logic [1:0]         i_mode,
    input  logic [SHAMT_W-1:0] i_shamt,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [OUT_W-1:0]   o_signal,
    output logic               o_ovf
);

    if (OUT_W < IN_W) begin : g_bad_width
        $error("imm_ext_pipe: OUT_W (%0d) must be >= IN_W (%0d)", OUT_W, IN_W);
    end
    if (OUT_W > MAX_W) begin : g_too_wide
        $error("imm_ext_pipe: OUT_W (%0d) exceeds helper width %0d", OUT_W, MAX_W);
    end

    logic [OUT_W-1:0] ext_sig;
    logic             ext_ovf;

    // The result is computed on the input side and stored with the word, so
    // a stalled word keeps its own mode and shift amount.
    always_comb begin
        ext_ovf = 1'b0;
        ext_sig = OUT_W'(ext_calc(MAX_W'(i_signal), ext_mode_e'(i_mode),
                                  32'(i_shamt), IN_W, OUT_W, ext_ovf));
    end

    imm_ext_pipe_skid_buf #(
        .W (OUT_W + 1)
    ) u_skid_buf (
        .core_clk (i_clk),
        .arst_n   (i_rst_n),
        .in_vld   (i_valid),
        .in_rdy   (o_ready),
        .in_dat   ({ext_ovf, ext_sig}),
        .out_vld  (o_valid),
        .out_rdy  (i_ready),
        .out_dat  ({o_ovf, o_signal})
    );

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Scoreboard bench for imm_ext_pipe (IN_W=11, OUT_W=16, SHAMT_W=3).
// Latency: not applicable.
// Backpressure: i_ready is driven fixed, toggling, or random.
module tb_imm_ext_pipe;

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [10:0] i_signal;
    logic [1:0]  i_mode;
    logic [2:0]  i_shamt;
    logic        o_valid;
    logic        i_ready;
    logic [15:0] o_signal;
    logic        o_ovf;

    logic [16:0] cur_exp;
    logic [16:0] exp_q[$];
    logic [16:0] mon_e;
    int          occ;
    int          errs;
    int          checks;
    bit          mon_acc;
    bit          mon_cons;
    bit          done;

    imm_ext_pipe #(
        .IN_W    (11),
        .OUT_W   (16),
        .SHAMT_W (3)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_signal (i_signal),
        .i_mode   (i_mode),
        .i_shamt  (i_shamt),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_signal (o_signal),
        .o_ovf    (o_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: plain integer arithmetic on signed values. Shift overflow
    // means the exact product no longer fits a 16-bit signed operand.
    function automatic logic [16:0] model(input logic [10:0] sig,
                                          input logic [1:0] mode,
                                          input logic [2:0] sh);
        int s;
        int v;
        bit ovf;
        s   = sig[10] ? int'(sig) - 2048 : int'(sig);
        ovf = 1'b0;
        v   = 0;
        case (mode)
            2'd0: v = int'(sig);
            2'd1: v = s;
            2'd2: v = int'(sig) * 32;
            default: begin
                v   = s * (1 << sh);
                ovf = (v < -32768) || (v > 32767);
            end
        endcase
        return {ovf, 16'(v)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: occupancy tracks words held inside the DUT; output words are
    // popped from the scoreboard on every downstream handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            occ = 0;
            exp_q.delete();
        end else begin
            chk("o_valid_vs_occupancy", o_valid, occ > 0);
            chk("o_ready_vs_skid", o_ready, occ < 2);
            mon_acc  = i_valid && o_ready;
            mon_cons = o_valid && i_ready;
            if (mon_cons) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errs++;
                    $display("FAIL unexpected_output: got %0h required none", {o_ovf, o_signal});
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("out_word", {o_ovf, o_signal}, mon_e);
                end
            end
            if (mon_acc) exp_q.push_back(cur_exp);
            occ = occ + int'(mon_acc) - int'(mon_cons);
        end
    end

    task automatic send(input logic [10:0] sig, input logic [1:0] mode,
                        input logic [2:0] sh, input logic [16:0] ex);
        bit got;
        got      = 1'b0;
        i_valid  = 1'b1;
        i_signal = sig;
        i_mode   = mode;
        i_shamt  = sh;
        cur_exp  = ex;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (o_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errs++;
            $display("FAIL accept_timeout: got no o_ready required accept of %0h", sig);
        end
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic send_rand();
        logic [10:0] s;
        logic [1:0]  m;
        logic [2:0]  h;
        s = 11'($urandom_range(0, 2047));
        m = 2'($urandom_range(0, 3));
        h = 3'($urandom_range(0, 7));
        send(s, m, h, model(s, m, h));
    endtask

    task automatic drain();
        bit empty;
        empty   = 1'b0;
        i_ready = 1'b1;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && occ == 0) begin
                empty = 1'b1;
                break;
            end
        end
        if (!empty) begin
            checks++;
            errs++;
            $display("FAIL drain_timeout: got %0d pending required 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [10:0] sig;
        logic [1:0]  mode;
        logic [2:0]  sh;
        logic [16:0] ex;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        errs = 0; checks = 0; occ = 0; done = 1'b0;
        rst_n = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
        i_signal = '0; i_mode = '0; i_shamt = '0; cur_exp = '0;

        vecs[0] = '{11'h7C0, 2'b01, 3'd0, 17'h0FFC0};
        vecs[1] = '{11'h7C0, 2'b00, 3'd5, 17'h007C0};
        vecs[2] = '{11'h7C0, 2'b10, 3'd7, 17'h0F800};
        vecs[3] = '{11'h072, 2'b01, 3'd0, 17'h00072};
        vecs[4] = '{11'h072, 2'b11, 3'd2, 17'h001C8};
        vecs[5] = '{11'h3FF, 2'b11, 3'd6, 17'h1FFC0};
        vecs[6] = '{11'h400, 2'b11, 3'd3, 17'h0E000};

        #1 rst_n = 1'b0;
        #10;
        chk("reset_o_valid", o_valid, 1'b0);
        chk("reset_o_ready", o_ready, 1'b1);
        chk("reset_o_signal", o_signal, 16'h0000);
        chk("reset_o_ovf", o_ovf, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors, back to back with the consumer always ready.
        foreach (vecs[k]) send(vecs[k].sig, vecs[k].mode, vecs[k].sh, vecs[k].ex);
        drain();

        // Backpressure: A to output, B to skid, C must wait.
        i_ready = 1'b0;
        send(11'h001, 2'b01, 3'd0, 17'h00001);
        send(11'h002, 2'b01, 3'd0, 17'h00002);
        i_valid  = 1'b1;
        i_signal = 11'h003;
        i_mode   = 2'b01;
        i_shamt  = 3'd0;
        cur_exp  = 17'h00003;
        @(negedge clk);
        chk("bp_o_ready_low", o_ready, 1'b0);
        chk("bp_hold_a_valid", o_valid, 1'b1);
        chk("bp_hold_a_data", o_signal, 16'h0001);
        repeat (2) begin
            @(negedge clk);
            chk("bp_c_blocked", o_ready, 1'b0);
        end
        @(posedge clk);
        #1 i_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_no_gap", o_valid, 1'b1);
            if (i_valid && o_ready) begin
                @(posedge clk);
                #1 i_valid = 1'b0;
            end
        end
        drain();

        // 20 random words with i_ready toggling every cycle.
        done = 1'b0;
        fork
            begin
                for (int k = 0; k < 20; k++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send_rand();
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 i_ready = ~i_ready;
                end
            end
        join
        drain();

        // Random stream with random consumer stalls.
        done = 1'b0;
        fork
            begin
                for (int k = 0; k < 40; k++) send_rand();
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 i_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        drain();

        // Asynchronous reset with output and skid both occupied.
        i_ready = 1'b0;
        send_rand();
        send_rand();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_o_valid", o_valid, 1'b0);
        chk("arst_o_signal", o_signal, 16'h0000);
        chk("arst_o_ovf", o_ovf, 1'b0);
        chk("arst_o_ready", o_ready, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1 i_ready = 1'b1;
        send(11'h155, 2'b00, 3'd0, 17'h00155);
        send_rand();
        drain();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
